// File: rtl/writeback_arbiter_if.sv
// Execute-write, load-tracking and register-file write signals of writeback_arbiter.
// master drives execute/load requests; slave is the arbiter.
interface writeback_arbiter_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic        ex_we;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic        ld_issue;
  logic [4:0]  ld_addr;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_pending;
  logic        ld_err;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output ex_valid, ex_instr, ex_pc, ex_we, ex_addr, ex_data,
    output ld_issue, ld_addr, ld_valid, ld_data,
    input  ex_ready, ld_pending, ld_err, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  ex_valid, ex_instr, ex_pc, ex_we, ex_addr, ex_data,
    input  ld_issue, ld_addr, ld_valid, ld_data,
    output ex_ready, ld_pending, ld_err, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file write scheduler: load returns (1 cycle) beat buffered execute writes (2 cycles);
// ex_ready drops when the FIFO is full; load returns never stall. LINK_JALR_EN adds JALR link decode.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               reset_n,
  writeback_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic [4:0]    ld_dst_q, ld_dst_d;
  logic          err_q, err_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       is_link, is_jalr, push_we, push, pop, ld_win, blocked, ready;
  wb_t        push_ent, head;

  assign opcode  = bus.ex_instr[31:26];
  assign rt      = bus.ex_instr[20:16];
  assign funct   = bus.ex_instr[5:0];
  assign is_link = (opcode == 6'b000011) ||
                   ((opcode == 6'b000001) && ((rt == 5'b10000) || (rt == 5'b10001)));
`ifdef LINK_JALR_EN
  assign is_jalr = (opcode == 6'b000000) && (funct == 6'b001001);
`else
  assign is_jalr = 1'b0;
`endif

  always_comb begin
    push_ent.addr = bus.ex_addr;
    push_ent.data = bus.ex_data;
    push_we       = bus.ex_we;
    if (is_link) begin
      push_ent.addr = 5'd31;
      push_ent.data = bus.ex_pc + 32'd8;
      push_we       = 1'b1;
    end else if (is_jalr) begin
      push_ent.addr = bus.ex_instr[15:11];
      push_ent.data = bus.ex_pc + 32'd8;
      push_we       = 1'b1;
    end
  end

  // ready looks only at the registered count, never at a same-cycle pop
  assign ready   = reset_n && (count_q != CW'(FIFO_DEPTH));
  assign push    = bus.ex_valid && ready && push_we && (push_ent.addr != 5'd0);
  assign head    = mem_q[rptr_q];
  assign ld_win  = bus.ld_valid && pend_q;
  assign blocked = pend_q && (head.addr == ld_dst_q);
  assign pop     = !ld_win && (count_q != '0) && !blocked;

  always_comb begin
    pend_d   = pend_q;
    ld_dst_d = ld_dst_q;
    err_d    = err_q;
    if (bus.ld_valid) begin
      if (pend_q) pend_d = 1'b0;
      else        err_d  = 1'b1;
    end
    if (bus.ld_issue) begin
      if (!pend_q || bus.ld_valid) begin
        pend_d   = 1'b1;
        ld_dst_d = bus.ld_addr;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (ld_win) begin
      if (ld_dst_q != 5'd0) begin
        rf_we_d   = 1'b1;
        rf_addr_d = ld_dst_q;
        rf_data_d = bus.ld_data;
      end
    end else if (pop) begin
      rf_we_d   = 1'b1;
      rf_addr_d = head.addr;
      rf_data_d = head.data;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      ld_dst_q  <= 5'd0;
      err_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      ld_dst_q  <= ld_dst_d;
      err_q     <= err_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.ex_ready   = ready;
  assign bus.ld_pending = pend_q;
  assign bus.ld_err     = err_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_data    = rf_data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a vector table of single execute ops plus
// hand-written load/WAW, full-FIFO, error and mid-operation reset sequences.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if bus ();

  writeback_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 1'b0;
    bus.ex_instr = 32'd0;
    bus.ex_pc    = 32'd0;
    bus.ex_we    = 1'b0;
    bus.ex_addr  = 5'd0;
    bus.ex_data  = 32'd0;
    bus.ld_issue = 1'b0;
    bus.ld_addr  = 5'd0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'd0;
  endtask

  // ADDU encoding; a plain non-link op
  task automatic drive_ex(input logic [4:0] a, input logic [31:0] d);
    bus.ex_valid = 1'b1;
    bus.ex_instr = 32'h0000_0021;
    bus.ex_pc    = 32'h0000_2000;
    bus.ex_we    = 1'b1;
    bus.ex_addr  = a;
    bus.ex_data  = d;
  endtask

  task automatic check_wr(input string nm, input logic [4:0] a, input logic [31:0] d);
    check({nm, ".we"}, 32'(bus.rf_we), 32'd1);
    check({nm, ".addr"}, 32'(bus.rf_addr), 32'(a));
    check({nm, ".data"}, bus.rf_data, d);
  endtask

  initial begin
    vecs[0] = '{"jal",         32'h0C00_0000, 32'h0040_0010, 1'b0, 5'd0, 32'd0,     1'b1, 5'd31, 32'h0040_0018};
    vecs[1] = '{"bgezal_wrap", 32'h0411_0000, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'd0,     1'b1, 5'd31, 32'h0000_0004};
    vecs[2] = '{"bltzal",      32'h0410_0000, 32'h0000_1000, 1'b1, 5'd3, 32'h77,    1'b1, 5'd31, 32'h0000_1008};
    vecs[3] = '{"bltz_plain",  32'h0400_0000, 32'h0000_1000, 1'b1, 5'd4, 32'h44,    1'b1, 5'd4,  32'h0000_0044};
    vecs[4] = '{"addu_r0",     32'h0000_0021, 32'h0000_1004, 1'b1, 5'd0, 32'h99,    1'b0, 5'd0,  32'd0};
    vecs[5] = '{"we0_discard", 32'h0000_0021, 32'h0000_1008, 1'b0, 5'd7, 32'h12,    1'b0, 5'd0,  32'd0};
`ifdef LINK_JALR_EN
    vecs[6] = '{"jalr",        32'h0000_6009, 32'h0000_0100, 1'b1, 5'd9, 32'h5,     1'b1, 5'd12, 32'h0000_0108};
`else
    vecs[6] = '{"jalr",        32'h0000_6009, 32'h0000_0100, 1'b1, 5'd9, 32'h5,     1'b1, 5'd9,  32'h0000_0005};
`endif
    vecs[7] = '{"jal_ign_we",  32'h0C00_0000, 32'hFFFF_FFF8, 1'b1, 5'd0, 32'h1,     1'b1, 5'd31, 32'h0000_0000};

    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    check("rst.ex_ready", 32'(bus.ex_ready), 32'd0);
    check("rst.rf_we", 32'(bus.rf_we), 32'd0);
    check("rst.rf_addr", 32'(bus.rf_addr), 32'd0);
    check("rst.rf_data", bus.rf_data, 32'd0);
    check("rst.ld_pending", 32'(bus.ld_pending), 32'd0);
    check("rst.ld_err", 32'(bus.ld_err), 32'd0);
    reset_n = 1'b1;
    step();
    check("rel.ex_ready", 32'(bus.ex_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_instr = vecs[i].instr;
      bus.ex_pc    = vecs[i].pc;
      bus.ex_we    = vecs[i].we;
      bus.ex_addr  = vecs[i].addr;
      bus.ex_data  = vecs[i].data;
      check({vecs[i].name, ".ready"}, 32'(bus.ex_ready), 32'd1);
      step();
      idle_inputs();
      check({vecs[i].name, ".t1_we"}, 32'(bus.rf_we), 32'd0);
      step();
      check({vecs[i].name, ".we"}, 32'(bus.rf_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check({vecs[i].name, ".addr"}, 32'(bus.rf_addr), 32'(vecs[i].exp_addr));
        check({vecs[i].name, ".data"}, bus.rf_data, vecs[i].exp_data);
      end
      step();
      check({vecs[i].name, ".one_cycle"}, 32'(bus.rf_we), 32'd0);
    end

    // WAW: younger writes to the load destination wait for the load
    bus.ld_issue = 1'b1; bus.ld_addr = 5'd5;
    step();
    idle_inputs();
    check("waw.pending", 32'(bus.ld_pending), 32'd1);
    drive_ex(5'd5, 32'h11);
    step();
    check("waw.c2_we", 32'(bus.rf_we), 32'd0);
    drive_ex(5'd6, 32'h22);
    step();
    idle_inputs();
    check("waw.c3_we", 32'(bus.rf_we), 32'd0);
    step();
    check("waw.c4_we", 32'(bus.rf_we), 32'd0);
    bus.ld_valid = 1'b1; bus.ld_data = 32'hAB;
    step();
    idle_inputs();
    check_wr("waw.load", 5'd5, 32'hAB);
    check("waw.pend_clr", 32'(bus.ld_pending), 32'd0);
    step();
    check_wr("waw.ex5", 5'd5, 32'h11);
    step();
    check_wr("waw.ex6", 5'd6, 32'h22);
    step();
    check("waw.done", 32'(bus.rf_we), 32'd0);

    // load beats a ready head; FIFO fills while blocked
    bus.ld_issue = 1'b1; bus.ld_addr = 5'd7;
    step();
    idle_inputs();
    drive_ex(5'd7, 32'h70);
    step();
    drive_ex(5'd8, 32'h80);
    step();
    drive_ex(5'd9, 32'h90);
    check("full.ready0", 32'(bus.ex_ready), 32'd0);
    bus.ld_valid = 1'b1; bus.ld_data = 32'hCD;
    step();
    idle_inputs();
    check_wr("full.load", 5'd7, 32'hCD);
    check("full.ready_still0", 32'(bus.ex_ready), 32'd0);
    step();
    check_wr("full.ex7", 5'd7, 32'h70);
    check("full.ready1", 32'(bus.ex_ready), 32'd1);
    step();
    check_wr("full.ex8", 5'd8, 32'h80);
    step();
    check("full.no_ex9", 32'(bus.rf_we), 32'd0);

    // double issue: second destination ignored, error sticky
    bus.ld_issue = 1'b1; bus.ld_addr = 5'd3;
    step();
    bus.ld_addr = 5'd4;
    step();
    idle_inputs();
    check("err.flag", 32'(bus.ld_err), 32'd1);
    check("err.pending", 32'(bus.ld_pending), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_data = 32'h33;
    step();
    idle_inputs();
    check_wr("err.first_dst", 5'd3, 32'h33);
    check("err.sticky", 32'(bus.ld_err), 32'd1);

    // reset mid-operation with a blocked entry queued
    bus.ld_issue = 1'b1; bus.ld_addr = 5'd10;
    step();
    idle_inputs();
    drive_ex(5'd10, 32'hAA);
    step();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("mid.ready_in_rst", 32'(bus.ex_ready), 32'd0);
    step();
    check("mid.rf_we", 32'(bus.rf_we), 32'd0);
    check("mid.rf_addr", 32'(bus.rf_addr), 32'd0);
    check("mid.rf_data", bus.rf_data, 32'd0);
    check("mid.pending", 32'(bus.ld_pending), 32'd0);
    check("mid.err", 32'(bus.ld_err), 32'd0);
    reset_n = 1'b1;
    step();
    check("mid.ready_rel", 32'(bus.ex_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid.fifo_empty", 32'(bus.rf_we), 32'd0);
    end
    bus.ld_valid = 1'b1; bus.ld_data = 32'h55;
    step();
    idle_inputs();
    check("mid.stale_ret_err", 32'(bus.ld_err), 32'd1);
    check("mid.stale_ret_nowr", 32'(bus.rf_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Single-port register-file write scheduler for the Harvard MIPS core. It merges two write sources onto one write port: execute-stage results, which are buffered in an in-order FIFO, and data-memory load returns, which cannot be stalled. It decodes link instructions so that they write PC+8 to $31. It also holds younger execute writes that would overtake an outstanding load to the same register (WAW).

## Interface
- FIFO_DEPTH, 2, execute-write buffer entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute write offered
- ex_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
- ex_instr  in  32  instruction word of offered op
- ex_pc  in  32  PC of offered op
- ex_we  in  1  op writes a register (non-link case)
- ex_addr  in  5  destination register (non-link case)
- ex_data  in  32  result (non-link case)
- ld_issue  in  1  load issued to data memory this cycle
- ld_addr  in  5  destination of issued load
- ld_valid  in  1  load data returned this cycle
- ld_data  in  32  returned load data
- ld_pending  out  1  a load is outstanding
- ld_err  out  1  sticky protocol-error flag
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data

## Operation
- **Accept.** An op is accepted when ex_valid && ex_ready.
- **Link decode.** A link op is opcode 000011 (JAL), or opcode 000001 with rt = 10000 or 10001 (BLTZAL/BGEZAL).
  - Link ops enqueue {31, ex_pc+8}. The add wraps modulo 2^32.
  - ex_we, ex_addr and ex_data are ignored for link ops.
- **Non-link ops.** If ex_we=1, enqueue {ex_addr, ex_data}. If ex_we=0, the op is accepted and discarded.
- **Register 0.** Any write whose destination is 0, from either source, is discarded at enqueue or at load return.
- **Load tracker.** Holds one entry: a pending bit plus a 5-bit destination.
  - ld_issue sets pending and captures ld_addr.
  - ld_valid with pending set clears pending.
  - ld_issue and ld_valid in the same cycle: the old load completes, the new one is captured, and pending stays 1.
  - ld_issue while pending, without ld_valid: the issue is ignored and ld_err is set.
  - ld_valid while not pending: the return is ignored and ld_err is set.
  - ld_err clears only on reset.
- **Write-port arbitration (per cycle):**
  1. A valid load return wins.
  2. Otherwise pop the FIFO head, unless pending=1 and head.addr equals the pending destination. In that case the head (and everything behind it) is held.
  3. Otherwise no write.
- **Ordering.** FIFO order is preserved. There are never two writes in one cycle.
- **Ready.** ex_ready depends on the registered count only, not on a same-cycle pop.

## Timing
- rf_we, rf_addr and rf_data are registered.
  - A write selected in cycle t appears in cycle t+1 for exactly one cycle.
  - rf_addr and rf_data hold their last values when rf_we=0.
- Load return: ld_valid in cycle t → rf_we=1 in cycle t+1.
- Execute write into an empty, unblocked FIFO: accepted in cycle t → rf_we=1 in cycle t+2.
- The blocked-head check uses the pending state at the start of the cycle. A head held by a load is popped in the cycle after that load's ld_valid, so it writes one cycle after the load.
- Push and pop in the same cycle: count is unchanged.
- Full FIFO: ex_ready=0 until the next pop edge.
- Reset (reset_n low at a rising edge), at any point including mid-operation:
  - FIFO emptied, pending=0, ld_err=0.
  - rf_we=0, rf_addr=0, rf_data=0.
  - ex_ready=0 while reset_n is low; 1 in the first cycle after release.
  - Any in-flight load return arriving after reset is treated as an error (sets ld_err).

## Configuration
- **LINK_JALR_EN.**
  - Defined: SPECIAL (opcode 000000) with funct 001001 (JALR) is also a link op. It enqueues {ex_instr[15:11], ex_pc+8}, and its rd=0 result is discarded.
  - Undefined: JALR is a normal op using ex_we, ex_addr and ex_data.

## Test plan
- Reset, then accept JAL (ex_instr[31:26]=000011, ex_pc=0x00400010) → rf_we=1, rf_addr=31, rf_data=0x00400018 two cycles later.
- BGEZAL with ex_pc=0xFFFFFFFC → rf_addr=31, rf_data=0x00000004 (wrap). ADDU writing $0 → no rf_we.
- ld_issue ld_addr=5; enqueue writes to $5 (0x11) then $6 (0x22); ld_valid ld_data=0xAB after 4 cycles → neither execute write occurs before the load. Writes come out in order: $5=0xAB, $5=0x11, $6=0x22, on consecutive cycles.
- ld_valid (pending) and a FIFO head to $7 in the same cycle → load written first, $7 written the next cycle. Fill FIFO_DEPTH entries while blocked → ex_ready=0 until the first pop.
- ld_issue twice without a return → ld_err=1, ld_pending=1, the second destination ignored. Then reset_n low for one edge → all outputs 0 and the FIFO empty.
- With LINK_JALR_EN: JALR rd=12, ex_pc=0x100 → rf_addr=12, rf_data=0x108. Without the macro: the same op with ex_we=1, ex_addr=9, ex_data=0x5 → rf_addr=9, rf_data=0x5.
